busca_instrucao: RTL and testbench
==================================

Name: busca_instrucao

Overview:
Instruction-fetch stage that sits directly upstream of memoria_instrucao. It owns the program counter, drives `pc` into the instruction memory, and captures the returned `instrucao` combinationally in the same cycle. The captured instruction goes into an IF/ID register, which is handed to the decoder through a valid/ready handshake. The stage also supports branch redirect (flush), decoder back-pressure (stall), and a sticky halt when the PC leaves the memory range.

Parameters:
TAMANHO_MEM, 64, number of valid instruction words; the PC is a word index, and addresses >= TAMANHO_MEM are out of range.
PC_RESET, 0, PC value loaded on reset.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
pc  output  64  word address driven to memoria_instrucao (equals the PC register)
instrucao_in  input  32  instruction word returned combinationally by memoria_instrucao
id_ready  input  1  decoder accepts the IF/ID contents this cycle
if_valid  output  1  IF/ID register holds a valid instruction
if_instrucao  output  32  captured instruction
if_pc  output  64  address of the captured instruction
redirect  input  1  branch/jump taken; flush and reload the PC
redirect_alvo  input  64  new PC (word index) when redirect=1
fora_limite  output  1  sticky flag: the PC reached an out-of-range address and fetch has stopped
cont_busca  output  32  count of instructions captured; saturates at 0xFFFFFFFF

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, also mid-stall or mid-redirect):
  - PC is set to PC_RESET.
  - if_valid, if_instrucao, if_pc, fora_limite and cont_busca are all set to 0.
- `pc` is a combinational copy of the PC register. Instruction-memory latency is zero, so the instruction is captured at the same edge that advances the PC.
- Accept: `aceita = if_valid & id_ready`.
- Fire condition: `dispara = !redirect & !fora_limite & (pc < TAMANHO_MEM) & (!if_valid | id_ready)`.
- Priority at each rising edge, highest first:
  1. redirect=1:
     - PC <= redirect_alvo; if_valid <= 0, discarding any held or stalled instruction.
     - fora_limite <= 0; no capture and no count increment.
     - This costs exactly one bubble cycle.
  2. dispara:
     - if_instrucao <= instrucao_in; if_pc <= PC; if_valid <= 1.
     - PC <= PC+1, 64-bit, wrapping modulo 2^64.
     - cont_busca increments, saturating.
  3. PC >= TAMANHO_MEM, fora_limite=0, and the IF/ID slot is free or being accepted:
     - fora_limite <= 1; PC is held.
     - if_valid <= 0 if aceita, otherwise if_valid holds.
  4. aceita with no fire: if_valid <= 0.
  5. Otherwise (stall, if_valid=1 & id_ready=0): the PC and every IF/ID field hold their values.
- While fora_limite=1, no fetch occurs; only a redirect (or reset) restarts the stage.
- A redirect to an out-of-range target sets fora_limite on the following edge (rule 3).
- redirect asserted together with id_ready: the decoder's acceptance completes in that cycle; the stage itself still only flushes.
- if_instrucao and if_pc hold stale values when if_valid=0. The decoder must gate on if_valid.
- Instruction word 0x00000000 is treated as ordinary data (a NOP); no special handling.

Test Plan:
- Reset, then release with id_ready=1, memory loaded with the standard test program:
  - edge 1: if_valid=1, if_pc=0, if_instrucao=0x00000000, pc=1.
  - edge 2: if_pc=1, if_instrucao=0x00102103.
  - edge 3: if_pc=2, if_instrucao=0x00208233; cont_busca=3.
- Stall: hold id_ready=0 for 3 cycles while if_pc=2 -> if_pc=2, if_instrucao=0x00208233 and pc=3 all stay stable. Raise id_ready -> next edge if_pc=3.
- Redirect during stall: with if_valid=1 and id_ready=0, pulse redirect=1 with redirect_alvo=5:
  - next edge: if_valid=0, pc=5, cont_busca unchanged.
  - following edge: if_pc=5, if_instrucao=0x00118193.
- Out of range: redirect to 62 with id_ready=1:
  - captures if_pc=62, then if_pc=63.
  - next edge: fora_limite=1, if_valid=0, pc=64 held; cont_busca stops incrementing.
  - redirect to 1 -> fora_limite=0, and the edge after that gives if_pc=1.
- Async reset mid-operation: assert rst_n=0 between clock edges while if_valid=1 -> if_valid=0, pc=0 and cont_busca=0 immediately, with no clock edge needed.
- Counter saturation: force cont_busca to 0xFFFFFFFE and fetch 3 instructions -> cont_busca reads 0xFFFFFFFF and stays there.

Source files
------------

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, captures the zero-latency memory word
// into an IF/ID register and hands it to the decoder with valid/ready.
module busca_instrucao #(
  parameter int unsigned TAMANHO_MEM = 64,
  parameter logic [63:0] PC_RESET    = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] pc,
  input  logic [31:0] instrucao_in,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instrucao,
  output logic [63:0] if_pc,
  input  logic        redirect,
  input  logic [63:0] redirect_alvo,
  output logic        fora_limite,
  output logic [31:0] cont_busca
);

  logic [63:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [63:0] ifpc_q;
  logic        fora_q;
  logic [31:0] cont_q;

  logic em_faixa;
  logic slot_livre;
  logic aceita;
  logic dispara;
  logic sai_limite;

  assign em_faixa   = (pc_q < 64'(TAMANHO_MEM));
  assign slot_livre = !valid_q || id_ready;
  assign aceita     = valid_q && id_ready;
  assign dispara    = !redirect && !fora_q && em_faixa && slot_livre;
  // Halt only once the held instruction (if any) has been handed over.
  assign sai_limite = !redirect && !fora_q && !em_faixa && slot_livre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_RESET;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      ifpc_q  <= 64'd0;
      fora_q  <= 1'b0;
      cont_q  <= 32'd0;
    end else if (redirect) begin
      pc_q    <= redirect_alvo;
      valid_q <= 1'b0;
      fora_q  <= 1'b0;
    end else if (dispara) begin
      instr_q <= instrucao_in;
      ifpc_q  <= pc_q;
      valid_q <= 1'b1;
      pc_q    <= pc_q + 64'd1;
      if (cont_q != 32'hFFFF_FFFF) begin
        cont_q <= cont_q + 32'd1;
      end
    end else if (sai_limite) begin
      fora_q <= 1'b1;
      if (aceita) begin
        valid_q <= 1'b0;
      end
    end else if (aceita) begin
      valid_q <= 1'b0;
    end
  end

  assign pc           = pc_q;
  assign if_valid     = valid_q;
  assign if_instrucao = instr_q;
  assign if_pc        = ifpc_q;
  assign fora_limite  = fora_q;
  assign cont_busca   = cont_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: a word-array memory, a reference
// model of the fetch rules checked every cycle, and literal anchors.
module tb_busca_instrucao;

  localparam int TAM = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc;
  logic [31:0] instrucao_in;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instrucao;
  logic [63:0] if_pc;
  logic        redirect = 1'b0;
  logic [63:0] redirect_alvo = 64'd0;
  logic        fora_limite;
  logic [31:0] cont_busca;

  int checks = 0;
  int failures = 0;
  logic check_en = 1'b0;

  logic [31:0] mem [TAM];

  busca_instrucao dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc(pc),
    .instrucao_in(instrucao_in),
    .id_ready(id_ready),
    .if_valid(if_valid),
    .if_instrucao(if_instrucao),
    .if_pc(if_pc),
    .redirect(redirect),
    .redirect_alvo(redirect_alvo),
    .fora_limite(fora_limite),
    .cont_busca(cont_busca)
  );

  always #5 clk = ~clk;

  // Zero-latency instruction memory; out-of-range reads return a marker word.
  assign instrucao_in = (pc < 64'(TAM)) ? mem[pc[5:0]] : 32'hDEAD_BEEF;

  initial begin
    for (int i = 0; i < TAM; i++) mem[i] = 32'h0A00_0000 | 32'(i);
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h0010_2103;
    mem[2] = 32'h0020_8233;
    mem[5] = 32'h0011_8193;
  end

  // Reference model: what the stage must hold after each edge.
  logic [63:0] m_pc = 64'd0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'd0;
  logic [63:0] m_ifpc = 64'd0;
  logic        m_fora = 1'b0;
  logic [31:0] m_cont = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 64'd0; m_valid = 1'b0; m_instr = 32'd0;
      m_ifpc = 64'd0; m_fora = 1'b0; m_cont = 32'd0;
    end else if (redirect) begin
      m_pc = redirect_alvo; m_valid = 1'b0; m_fora = 1'b0;
    end else if (m_fora) begin
      if (id_ready) m_valid = 1'b0;
    end else if (m_valid && !id_ready) begin
      // decoder stalled: nothing moves
    end else if (m_pc < 64'(TAM)) begin
      m_instr = mem[m_pc[5:0]];
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 64'd1;
      if (m_cont != 32'hFFFF_FFFF) m_cont = m_cont + 32'd1;
    end else begin
      m_fora  = 1'b1;
      m_valid = 1'b0;
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("model_pc", pc, m_pc);
      check_output("model_if_valid", 64'(if_valid), 64'(m_valid));
      check_output("model_fora_limite", 64'(fora_limite), 64'(m_fora));
      check_output("model_cont_busca", 64'(cont_busca), 64'(m_cont));
      if (m_valid) begin
        check_output("model_if_pc", if_pc, m_ifpc);
        check_output("model_if_instrucao", 64'(if_instrucao), 64'(m_instr));
      end
    end
  end

  task automatic apply_stimulus(input logic r, input logic [63:0] alvo, input logic rdy);
    redirect = r;
    redirect_alvo = alvo;
    id_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from reset
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("e1_valid", 64'(if_valid), 64'd1);
    check_output("e1_if_pc", if_pc, 64'd0);
    check_output("e1_instr", 64'(if_instrucao), 64'h0000_0000);
    check_output("e1_pc", pc, 64'd1);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("e2_if_pc", if_pc, 64'd1);
    check_output("e2_instr", 64'(if_instrucao), 64'h0010_2103);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("e3_if_pc", if_pc, 64'd2);
    check_output("e3_instr", 64'(if_instrucao), 64'h0020_8233);
    check_output("e3_cont", 64'(cont_busca), 64'd3);

    // Decoder stall
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 64'd0, 1'b0);
      check_output("stall_if_pc", if_pc, 64'd2);
      check_output("stall_instr", 64'(if_instrucao), 64'h0020_8233);
      check_output("stall_pc", pc, 64'd3);
    end
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("unstall_if_pc", if_pc, 64'd3);

    // Redirect while stalled
    apply_stimulus(1'b0, 64'd0, 1'b0);
    apply_stimulus(1'b1, 64'd5, 1'b0);
    check_output("redir_valid", 64'(if_valid), 64'd0);
    check_output("redir_pc", pc, 64'd5);
    check_output("redir_cont", 64'(cont_busca), 64'd4);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("redir_if_pc", if_pc, 64'd5);
    check_output("redir_instr", 64'(if_instrucao), 64'h0011_8193);

    // Running off the end of memory
    apply_stimulus(1'b1, 64'd62, 1'b1);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("oor_if_pc62", if_pc, 64'd62);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("oor_if_pc63", if_pc, 64'd63);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("oor_fora", 64'(fora_limite), 64'd1);
    check_output("oor_valid", 64'(if_valid), 64'd0);
    check_output("oor_pc", pc, 64'd64);
    check_output("oor_cont", 64'(cont_busca), 64'd7);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("oor_hold_cont", 64'(cont_busca), 64'd7);
    check_output("oor_hold_pc", pc, 64'd64);
    apply_stimulus(1'b1, 64'd1, 1'b1);
    check_output("oor_clear", 64'(fora_limite), 64'd0);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("oor_restart_if_pc", if_pc, 64'd1);

    // Redirect straight to an out-of-range target
    apply_stimulus(1'b1, 64'd100, 1'b1);
    check_output("far_fora0", 64'(fora_limite), 64'd0);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("far_fora1", 64'(fora_limite), 64'd1);
    check_output("far_pc", pc, 64'd100);
    apply_stimulus(1'b1, 64'd0, 1'b1);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("pre_reset_valid", 64'(if_valid), 64'd1);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check_output("areset_valid", 64'(if_valid), 64'd0);
    check_output("areset_pc", pc, 64'd0);
    check_output("areset_cont", 64'(cont_busca), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 64'd0, 1'b1);
    apply_stimulus(1'b0, 64'd0, 1'b1);
    check_output("post_reset_cont", 64'(cont_busca), 64'd2);

    // Counter saturation
    #2;
    force dut.cont_q = 32'hFFFF_FFFE;
    m_cont = 32'hFFFF_FFFE;
    #1;
    release dut.cont_q;
    check_output("sat_preload", 64'(cont_busca), 64'h0000_0000_FFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 64'd0, 1'b1);
      check_output("sat_cont", 64'(cont_busca), 64'h0000_0000_FFFF_FFFF);
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
